// File: rtl/line_engine_pkg.sv
// line_engine_pkg: shared types and constants for the Bresenham line engine.
//   state_t    : FSM states (IDLE, SETUP, ORDER, DRAW)
//   coord_t    : 10-bit unsigned screen coordinate
//   err_t      : 12-bit signed Bresenham error term
//   pixel_addr : framebuffer byte address of a pixel (row pitch 4 KB, 4 B/pixel)
package line_engine_pkg;

  localparam logic [31:0] FB_BASE_DEF = 32'h1080_0000;
  localparam int          WIDTH_DEF   = 800;
  localparam int          HEIGHT_DEF  = 600;
  localparam int          ROW_SHIFT   = 12;
  localparam int          COORD_W     = 10;
  localparam int          ERR_W       = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ORDER = 2'd2,
    DRAW  = 2'd3
  } state_t;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [ERR_W-1:0]   err_t;

  function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                             input coord_t      x,
                                             input coord_t      y);
    return base + (32'(y) << ROW_SHIFT) + (32'(x) << 2);
  endfunction

endpackage

// File: rtl/line_engine_if.sv
// line_engine_if: pixel write port from the line engine into the framebuffer path.
//   px_valid : pixel write request (driven by master)
//   px_ready : downstream accepts the pixel (driven by slave)
//   px_addr  : pixel byte address
//   px_data  : pixel color word
interface line_engine_if;
  logic        px_valid;
  logic        px_ready;
  logic [31:0] px_addr;
  logic [31:0] px_data;

  modport master (output px_valid, output px_addr, output px_data, input px_ready);
  modport slave  (input px_valid, input px_addr, input px_data, output px_ready);
endinterface

// File: rtl/line_pixel_port.sv
// line_pixel_port: one-entry output register for the plotted pixel stream.
//   clk, rst    : clock, asynchronous active-low reset
//   load        : register a new plotted point as the current step
//   pt_x, pt_y  : plotted point (screen coordinates)
//   color       : color for the point
//   step_done   : current step completes this cycle (accepted, or clipped)
//   px          : pixel write port (master side)
// A clipped point still occupies one step, but with px_valid low, so the
// step completes unconditionally. A visible point holds addr/data until
// px_ready is seen.
module line_pixel_port
  import line_engine_pkg::*;
#(
  parameter logic [31:0] FB_BASE = FB_BASE_DEF,
  parameter int          WIDTH   = WIDTH_DEF,
  parameter int          HEIGHT  = HEIGHT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  coord_t       pt_x,
  input  coord_t       pt_y,
  input  logic [31:0]  color,
  output logic         step_done,
  line_engine_if.master px
);

  logic loaded;
  logic in_range;

  assign in_range  = (32'(pt_x) < 32'(WIDTH)) && (32'(pt_y) < 32'(HEIGHT));
  assign step_done = loaded && (!px.px_valid || px.px_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded      <= 1'b0;
      px.px_valid <= 1'b0;
      px.px_addr  <= '0;
      px.px_data  <= '0;
    end else if (load) begin
      // The FSM only loads when the previous step is done (or none is pending).
      loaded      <= 1'b1;
      px.px_valid <= in_range;
      px.px_addr  <= pixel_addr(FB_BASE, pt_x, pt_y);
      px.px_data  <= color;
    end else if (step_done) begin
      loaded      <= 1'b0;
      px.px_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/line_engine.sv
// line_engine: Bresenham line rasterizer fed by the core's line-engine strobes.
//   clk, rst          : clock, asynchronous active-low reset
//   line_color        : color word, latched on line_color_valid
//   line_point        : coordinate, latched by any line_{x0,y0,x1,y1}_valid
//   line_*_valid      : shadow register write strobes
//   line_trigger      : start drawing the shadowed line (only honoured in IDLE)
//   line_ready        : engine idle, trigger will be accepted
//   px                : pixel write port (valid/ready), one pixel per cycle
module line_engine
  import line_engine_pkg::*;
#(
  parameter logic [31:0] FB_BASE = FB_BASE_DEF,
  parameter int          WIDTH   = WIDTH_DEF,
  parameter int          HEIGHT  = HEIGHT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_color,
  input  coord_t       line_point,
  input  logic         line_color_valid,
  input  logic         line_x0_valid,
  input  logic         line_y0_valid,
  input  logic         line_x1_valid,
  input  logic         line_y1_valid,
  input  logic         line_trigger,
  output logic         line_ready,
  line_engine_if.master px
);

  state_t      state;

  // shadow registers written by the core
  coord_t      sx0, sy0, sx1, sy1;
  logic [31:0] scolor;

  // working copy, already swapped so the major axis is x
  coord_t      wx0, wy0, wx1, wy1;
  logic [31:0] wcolor;
  logic        steep;

  // Bresenham walk state
  coord_t      cx, cy, xend;
  logic [10:0] dx, dy;
  err_t        err;
  logic        ystep_neg;

  // pixel port handshake
  logic        load;
  coord_t      pt_x, pt_y;
  logic        step_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx0    <= '0;
      sy0    <= '0;
      sx1    <= '0;
      sy1    <= '0;
      scolor <= '0;
    end else begin
      if (line_x0_valid)    sx0    <= line_point;
      if (line_y0_valid)    sy0    <= line_point;
      if (line_x1_valid)    sx1    <= line_point;
      if (line_y1_valid)    sy1    <= line_point;
      if (line_color_valid) scolor <= line_color;
    end
  end

  // SETUP: steepness from the shadow endpoints
  coord_t adx, ady;
  logic   steep_c;
  assign adx     = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
  assign ady     = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
  assign steep_c = ady > adx;

  // ORDER: left-to-right endpoints and deltas
  logic        swap_c;
  coord_t      ox0, oy0, ox1, oy1;
  logic [10:0] odx, ody;
  assign swap_c = wx0 > wx1;
  assign ox0    = swap_c ? wx1 : wx0;
  assign oy0    = swap_c ? wy1 : wy0;
  assign ox1    = swap_c ? wx0 : wx1;
  assign oy1    = swap_c ? wy0 : wy1;
  assign odx    = {1'b0, ox1} - {1'b0, ox0};
  assign ody    = (oy1 >= oy0) ? {1'b0, oy1 - oy0} : {1'b0, oy0 - oy1};

  // DRAW: next point of the walk
  err_t   e_next, err_adv;
  coord_t cx_adv, cy_adv;
  assign e_next  = err - $signed({1'b0, dy});
  assign err_adv = e_next[ERR_W-1] ? e_next + $signed({1'b0, dx}) : e_next;
  assign cy_adv  = e_next[ERR_W-1] ? (ystep_neg ? cy - 1'b1 : cy + 1'b1) : cy;
  assign cx_adv  = cx + 1'b1;

  // The pixel register is loaded one edge ahead of the step it shows, so the
  // first point goes out at the ORDER->DRAW edge and each later point at the
  // edge where the previous step completes.
  always_comb begin
    load = 1'b0;
    pt_x = '0;
    pt_y = '0;
    case (state)
      ORDER: begin
        load = 1'b1;
        pt_x = steep ? oy0 : ox0;
        pt_y = steep ? ox0 : oy0;
      end
      DRAW: begin
        load = step_done && (cx != xend);
        pt_x = steep ? cy_adv : cx_adv;
        pt_y = steep ? cx_adv : cy_adv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      line_ready <= 1'b1;
      wx0        <= '0;
      wy0        <= '0;
      wx1        <= '0;
      wy1        <= '0;
      wcolor     <= '0;
      steep      <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      xend       <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      ystep_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_trigger) begin
            state      <= SETUP;
            line_ready <= 1'b0;
          end
        end
        SETUP: begin
          steep  <= steep_c;
          wx0    <= steep_c ? sy0 : sx0;
          wy0    <= steep_c ? sx0 : sy0;
          wx1    <= steep_c ? sy1 : sx1;
          wy1    <= steep_c ? sx1 : sy1;
          wcolor <= scolor;
          state  <= ORDER;
        end
        ORDER: begin
          cx        <= ox0;
          cy        <= oy0;
          xend      <= ox1;
          dx        <= odx;
          dy        <= ody;
          err       <= $signed({2'b00, odx[10:1]});
          ystep_neg <= !(oy0 < oy1);
          state     <= DRAW;
        end
        DRAW: begin
          if (step_done) begin
            if (cx == xend) begin
              state      <= IDLE;
              line_ready <= 1'b1;
            end else begin
              cx  <= cx_adv;
              cy  <= cy_adv;
              err <= err_adv;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_pixel_port #(
    .FB_BASE (FB_BASE),
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT)
  ) u_port (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .color     (wcolor),
    .step_done (step_done),
    .px        (px)
  );

endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed self-checking bench for line_engine.
module tb_line_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid;
  logic        line_x0_valid;
  logic        line_y0_valid;
  logic        line_x1_valid;
  logic        line_y1_valid;
  logic        line_trigger;
  logic        line_ready;

  line_engine_if pxif();

  line_engine dut (
    .clk              (clk),
    .rst              (rst),
    .line_color       (line_color),
    .line_point       (line_point),
    .line_color_valid (line_color_valid),
    .line_x0_valid    (line_x0_valid),
    .line_y0_valid    (line_y0_valid),
    .line_x1_valid    (line_x1_valid),
    .line_y1_valid    (line_y1_valid),
    .line_trigger     (line_trigger),
    .line_ready       (line_ready),
    .px               (pxif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];

  // record every accepted pixel (handshake sampled mid-cycle)
  always @(negedge clk) begin
    if (rst && pxif.px_valid && pxif.px_ready) begin
      got_addr.push_back(pxif.px_addr);
      got_data.push_back(pxif.px_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int which, input logic [9:0] v);
    line_point = v;
    case (which)
      0: line_x0_valid = 1'b1;
      1: line_y0_valid = 1'b1;
      2: line_x1_valid = 1'b1;
      default: line_y1_valid = 1'b1;
    endcase
    tick();
    line_x0_valid = 1'b0;
    line_y0_valid = 1'b0;
    line_x1_valid = 1'b0;
    line_y1_valid = 1'b0;
  endtask

  task automatic set_line(input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input logic [31:0] color);
    strobe(0, x0);
    strobe(1, y0);
    strobe(2, x1);
    strobe(3, y1);
    line_color       = color;
    line_color_valid = 1'b1;
    tick();
    line_color_valid = 1'b0;
  endtask

  task automatic pulse_trigger();
    line_trigger = 1'b1;
    tick();
    line_trigger = 1'b0;
  endtask

  // Called in the SETUP cycle; counts busy cycles until line_ready returns.
  task automatic wait_idle(input string tag, input int max, output int busy);
    busy = 0;
    while (!line_ready && busy < max) begin
      busy++;
      tick();
    end
    check_val({tag, "_ready"}, 32'(line_ready), 32'd1);
  endtask

  task automatic compare_pixels(input string tag, input logic [31:0] color);
    int n;
    check_val({tag, "_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check_val($sformatf("%s_data%0d", tag, i), got_data[i], color);
    end
  endtask

  task automatic clear_q();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
  endtask

  initial begin
    int busy;
    rst              = 1'b0;
    line_color       = '0;
    line_point       = '0;
    line_color_valid = 1'b0;
    line_x0_valid    = 1'b0;
    line_y0_valid    = 1'b0;
    line_x1_valid    = 1'b0;
    line_y1_valid    = 1'b0;
    line_trigger     = 1'b0;
    pxif.px_ready    = 1'b1;

    // reset state
    tick();
    tick();
    check_val("rst_ready", 32'(line_ready), 32'd1);
    check_val("rst_valid", 32'(pxif.px_valid), 32'd0);
    check_val("rst_addr", pxif.px_addr, 32'h0);
    check_val("rst_data", pxif.px_data, 32'h0);
    rst = 1'b1;
    tick();

    // horizontal line, cycle-exact
    set_line(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF_0000);
    clear_q();
    pulse_trigger();
    check_val("hz_setup_ready", 32'(line_ready), 32'd0);
    check_val("hz_setup_valid", 32'(pxif.px_valid), 32'd0);
    tick();
    check_val("hz_order_valid", 32'(pxif.px_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("hz_valid%0d", i), 32'(pxif.px_valid), 32'd1);
      check_val($sformatf("hz_addr%0d", i), pxif.px_addr, 32'h1080_0000 + 32'(4 * i));
      check_val($sformatf("hz_data%0d", i), pxif.px_data, 32'h00FF_0000);
    end
    tick();
    check_val("hz_end_ready", 32'(line_ready), 32'd1);
    check_val("hz_end_valid", 32'(pxif.px_valid), 32'd0);
    check_val("hz_count", 32'(got_addr.size()), 32'd4);

    // steep line (2,1)->(3,5)
    set_line(10'd2, 10'd1, 10'd3, 10'd5, 32'h0000_00AB);
    clear_q();
    exp_addr = '{32'h1080_1008, 32'h1080_2008, 32'h1080_3008, 32'h1080_400C, 32'h1080_500C};
    pulse_trigger();
    wait_idle("steep", 50, busy);
    check_val("steep_busy", 32'(busy), 32'd7);
    compare_pixels("steep", 32'h0000_00AB);

    // reversed endpoints (3,0)->(0,0)
    set_line(10'd3, 10'd0, 10'd0, 10'd0, 32'h1234_5678);
    clear_q();
    exp_addr = '{32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C};
    pulse_trigger();
    wait_idle("rev", 50, busy);
    compare_pixels("rev", 32'h1234_5678);

    // backpressure at the second pixel of the horizontal line
    set_line(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF_0000);
    clear_q();
    exp_addr = '{32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C};
    pulse_trigger();
    tick();
    tick();
    check_val("bp_first", pxif.px_addr, 32'h1080_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      pxif.px_ready = (i == 3);
      check_val($sformatf("bp_hold_valid%0d", i), 32'(pxif.px_valid), 32'd1);
      check_val($sformatf("bp_hold_addr%0d", i), pxif.px_addr, 32'h1080_0004);
    end
    wait_idle("bp", 50, busy);
    compare_pixels("bp", 32'h00FF_0000);

    // clipping at the right edge
    set_line(10'd798, 10'd10, 10'd801, 10'd10, 32'h00C0_FFEE);
    clear_q();
    exp_addr = '{32'h1080_AC78, 32'h1080_AC7C};
    pulse_trigger();
    wait_idle("clip", 50, busy);
    check_val("clip_busy", 32'(busy), 32'd6);
    compare_pixels("clip", 32'h00C0_FFEE);

    // degenerate single-pixel line
    set_line(10'd7, 10'd7, 10'd7, 10'd7, 32'h0000_0077);
    clear_q();
    exp_addr = '{32'h1080_701C};
    pulse_trigger();
    wait_idle("dot", 50, busy);
    check_val("dot_busy", 32'(busy), 32'd3);
    compare_pixels("dot", 32'h0000_0077);

    // trigger and x1 strobe while drawing
    set_line(10'd0, 10'd0, 10'd3, 10'd0, 32'h0000_5555);
    clear_q();
    exp_addr = '{32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C};
    pulse_trigger();
    tick();
    tick();
    line_trigger  = 1'b1;
    line_x1_valid = 1'b1;
    line_point    = 10'd5;
    tick();
    line_trigger  = 1'b0;
    line_x1_valid = 1'b0;
    wait_idle("busy", 50, busy);
    compare_pixels("busy", 32'h0000_5555);
    tick();
    tick();
    check_val("busy_noqueue_ready", 32'(line_ready), 32'd1);
    check_val("busy_noqueue_valid", 32'(pxif.px_valid), 32'd0);
    clear_q();
    exp_addr = '{32'h1080_0000, 32'h1080_0004, 32'h1080_0008,
                 32'h1080_000C, 32'h1080_0010, 32'h1080_0014};
    pulse_trigger();
    wait_idle("next", 50, busy);
    compare_pixels("next", 32'h0000_5555);

    // asynchronous reset mid-line
    set_line(10'd0, 10'd0, 10'd20, 10'd0, 32'h00AA_00AA);
    pulse_trigger();
    tick();
    tick();
    tick();
    check_val("ar_pre_valid", 32'(pxif.px_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("ar_valid", 32'(pxif.px_valid), 32'd0);
    check_val("ar_ready", 32'(line_ready), 32'd1);
    check_val("ar_addr", pxif.px_addr, 32'h0);
    check_val("ar_data", pxif.px_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check_val("ar_after_valid", 32'(pxif.px_valid), 32'd0);
    // shadow registers were cleared: next line is the single pixel (0,0), color 0
    clear_q();
    exp_addr = '{32'h1080_0000};
    pulse_trigger();
    wait_idle("ar_next", 50, busy);
    compare_pixels("ar_next", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
